// File: rtl/fifo_block_reader.sv
// Pulls 64-bit message words from an upstream FIFO into SHA3-256 rate blocks of
// 17 lanes. It applies the 0x06/0x80 padding and hands each block downstream
// with a valid/ready handshake.
module fifo_block_reader #(
    parameter int WIDTH      = 64,
    parameter int RATE_LANES = 17,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            msg_words,
    input  logic [3:0]                  last_bytes,
    input  logic [WIDTH-1:0]            fifo_data,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    output logic [RATE_LANES*WIDTH-1:0] block_data,
    output logic                        block_valid,
    input  logic                        block_ready,
    output logic                        block_last,
    output logic                        busy,
    output logic                        done
);

    localparam int LANE_IDX_W = $clog2(RATE_LANES + 1);
    localparam int BYTES      = WIDTH / 8;
    localparam int BYTE_IDX_W = $clog2(BYTES);
    localparam logic [3:0]            FULL_BYTES = 4'(BYTES);
    localparam logic [LANE_IDX_W-1:0] LANE_END   = LANE_IDX_W'(RATE_LANES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        PAD     = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic [3:0]             last_bytes_q, last_bytes_d;
    logic [LANE_IDX_W-1:0]  lane_idx_q, lane_idx_d;
    logic                   last_q, last_d;

    logic                   final_word;
    logic [CNT_W-1:0]       rem_dec;
    logic [LANE_IDX_W-1:0]  lane_idx_inc;
    logic                   accept;
    logic [WIDTH-1:0]       capture_word;
    logic [LANE_IDX_W-1:0]  pad_lane;
    logic [BYTE_IDX_W-1:0]  pad_byte;

    assign final_word   = (remaining_q == CNT_W'(1));
    assign rem_dec      = (remaining_q != '0) ? remaining_q - CNT_W'(1) : '0;
    assign lane_idx_inc = lane_idx_q + LANE_IDX_W'(1);
    assign accept       = (state_q == EMIT) && block_ready;

    // Bytes past the message end in the final word are dropped so padding XORs into zeros.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
        logic keep_byte;
        assign keep_byte = !final_word || (last_bytes_q > 4'(gi));
        assign capture_word[gi*8 +: 8] = keep_byte ? fifo_data[gi*8 +: 8] : 8'h00;
    end

    // A block with no captured word (empty message, or block-exact tail) pads at lane 0.
    always_comb begin
        pad_lane = '0;
        pad_byte = '0;
        if (lane_idx_q != '0) begin
            if (last_bytes_q < FULL_BYTES) begin
                pad_lane = lane_idx_q - LANE_IDX_W'(1);
                pad_byte = last_bytes_q[BYTE_IDX_W-1:0];
            end else begin
                pad_lane = lane_idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (msg_words != '0) ? FETCH : PAD;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // A full final word landing in the last lane leaves no room for padding.
                if ((rem_dec == '0) &&
                    !((lane_idx_inc == LANE_END) && (last_bytes_q >= FULL_BYTES))) begin
                    state_d = PAD;
                end else if (lane_idx_inc == LANE_END) begin
                    state_d = EMIT;
                end else begin
                    state_d = FETCH;
                end
            end
            PAD: state_d = EMIT;
            EMIT: begin
                if (accept) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else if (remaining_q != '0) begin
                        state_d = FETCH;
                    end else begin
                        state_d = PAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en  = (state_q == FETCH) && !fifo_empty && !reset;
        block_valid = (state_q == EMIT);
        block_last  = (state_q == EMIT) && last_q;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
    end

    always_comb begin
        remaining_d  = remaining_q;
        last_bytes_d = last_bytes_q;
        lane_idx_d   = lane_idx_q;
        last_d       = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d  = msg_words;
                    last_bytes_d = last_bytes;
                    lane_idx_d   = '0;
                    last_d       = 1'b0;
                end
            end
            CAPTURE: begin
                remaining_d = rem_dec;
                lane_idx_d  = lane_idx_inc;
            end
            PAD: last_d = 1'b1;
            EMIT: begin
                if (accept && !last_q) begin
                    lane_idx_d = '0;
                end
            end
            DONE:    last_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q  <= '0;
            last_bytes_q <= '0;
            lane_idx_q   <= '0;
            last_q       <= 1'b0;
        end else begin
            remaining_q  <= remaining_d;
            last_bytes_q <= last_bytes_d;
            lane_idx_q   <= lane_idx_d;
            last_q       <= last_d;
        end
    end

    for (genvar gi = 0; gi < RATE_LANES; gi++) begin : g_lane
        localparam bit IS_TOP = (gi == RATE_LANES - 1);
        logic [WIDTH-1:0] lane_q, lane_d;

        always_comb begin
            lane_d = lane_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lane_d = '0;
                    end
                end
                CAPTURE: begin
                    if (lane_idx_q == LANE_IDX_W'(gi)) begin
                        lane_d = capture_word;
                    end
                end
                PAD: begin
                    // Both XORs may hit the top byte of the last lane, giving 0x86.
                    if (pad_lane == LANE_IDX_W'(gi)) begin
                        lane_d[{pad_byte, 3'b000} +: 8] = lane_d[{pad_byte, 3'b000} +: 8] ^ 8'h06;
                    end
                    if (IS_TOP) begin
                        lane_d[WIDTH-1 -: 8] = lane_d[WIDTH-1 -: 8] ^ 8'h80;
                    end
                end
                EMIT: begin
                    if (accept && !last_q) begin
                        lane_d = '0;
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                lane_q <= '0;
            end else begin
                lane_q <= lane_d;
            end
        end

        assign block_data[gi*WIDTH +: WIDTH] = lane_q;
    end

endmodule

// File: tb/tb_fifo_block_reader.sv
// Directed and randomized checks of fifo_block_reader against a byte-level
// padding model (message bytes, 0x06, zero fill, 0x80 on the last rate byte).
module tb_fifo_block_reader;

    localparam int WIDTH      = 64;
    localparam int RATE_LANES = 17;
    localparam int CNT_W      = 16;
    localparam int RATE_BYTES = RATE_LANES * 8;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        start;
    logic [CNT_W-1:0]            msg_words;
    logic [3:0]                  last_bytes;
    logic [WIDTH-1:0]            fifo_data;
    logic                        fifo_empty;
    logic                        fifo_rd_en;
    logic [RATE_LANES*WIDTH-1:0] block_data;
    logic                        block_valid;
    logic                        block_ready;
    logic                        block_last;
    logic                        busy;
    logic                        done;

    fifo_block_reader #(.WIDTH(WIDTH), .RATE_LANES(RATE_LANES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .msg_words  (msg_words),
        .last_bytes (last_bytes),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .block_data (block_data),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .block_last (block_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [63:0] fifo_q[$];
    logic [63:0] sent[$];
    logic [7:0]  exp_b[$];
    bit          rand_empty = 1'b0;
    int          pops = 0;
    int          rd_viol = 0;
    int          checks = 0;
    int          failures = 0;

    // Upstream FIFO model: read data appears the cycle after the pop.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty || fifo_q.size() == 0) begin
                rd_viol <= rd_viol + 1;
            end else begin
                fifo_data <= fifo_q.pop_front();
                pops      <= pops + 1;
            end
        end
    end

    always @(negedge clk) begin
        fifo_empty <= (fifo_q.size() == 0) || (rand_empty && ($urandom_range(0, 1) == 1));
    end

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Reference: the padded message as a flat byte stream cut into 136-byte blocks.
    task automatic build_expected(input int n, input int lb);
        exp_b.delete();
        for (int i = 0; i < n; i++) begin
            int cnt;
            logic [63:0] w;
            w   = sent[i];
            cnt = (i == n - 1) ? lb : 8;
            for (int k = 0; k < cnt; k++) exp_b.push_back(w[k*8 +: 8]);
        end
        exp_b.push_back(8'h06);
        while ((exp_b.size() % RATE_BYTES) != 0) exp_b.push_back(8'h00);
        exp_b[exp_b.size() - 1] = exp_b[exp_b.size() - 1] ^ 8'h80;
    endtask

    function automatic logic [63:0] exp_lane(input int b, input int l);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = exp_b[b*RATE_BYTES + l*8 + k];
        return v;
    endfunction

    task automatic run_msg(input int n, input int lb, input bit rnd, input bit stall,
                           input bit use_fixed, input logic [63:0] fixed);
        int nblk;
        int pops0;
        int viol0;
        int to;
        logic [RATE_LANES*WIDTH-1:0] snap;
        int p;
        sent.delete();
        for (int i = 0; i < n; i++) begin
            logic [63:0] w;
            w = use_fixed ? fixed : {$urandom, $urandom};
            sent.push_back(w);
            fifo_q.push_back(w);
        end
        build_expected(n, lb);
        nblk        = exp_b.size() / RATE_BYTES;
        pops0       = pops;
        viol0       = rd_viol;
        rand_empty  = rnd;
        block_ready = !stall;
        @(negedge clk);
        start      = 1'b1;
        msg_words  = CNT_W'(n);
        last_bytes = 4'(lb);
        @(negedge clk);
        start = 1'b0;
        check64("busy_after_start", 64'(busy), 64'd1);
        for (int b = 0; b < nblk; b++) begin
            to = 0;
            while (!block_valid && to < 5000) begin
                @(negedge clk);
                to++;
            end
            if (!block_valid) begin
                timeout_fail("block_valid_wait");
                rand_empty = 1'b0;
                return;
            end
            if (stall) begin
                snap = block_data;
                p    = pops;
                start     = 1'b1;
                msg_words = CNT_W'(3);
                repeat (10) begin
                    @(negedge clk);
                    start = 1'b0;
                end
                check64("stall_valid", 64'(block_valid), 64'd1);
                check64("stall_data_stable", 64'(block_data == snap), 64'd1);
                check64("stall_no_pops", 64'(pops), 64'(p));
                block_ready = 1'b1;
            end
            for (int l = 0; l < RATE_LANES; l++) begin
                check64($sformatf("n%0d_b%0d_lane%0d", n, b, l), block_data[l*64 +: 64], exp_lane(b, l));
            end
            check64($sformatf("n%0d_b%0d_last", n, b), 64'(block_last), 64'(b == nblk - 1));
            @(negedge clk);
            if (stall) block_ready = 1'b0;
            check64($sformatf("n%0d_b%0d_done", n, b), 64'(done), 64'(b == nblk - 1));
        end
        @(negedge clk);
        check64("done_one_cycle", 64'(done), 64'd0);
        check64("idle_busy", 64'(busy), 64'd0);
        check64($sformatf("n%0d_pops", n), 64'(pops - pops0), 64'(n));
        check64("rd_en_while_empty", 64'(rd_viol - viol0), 64'd0);
        rand_empty  = 1'b0;
        block_ready = 1'b1;
        $display("msg words=%0d last_bytes=%0d blocks=%0d pops=%0d", n, lb, nblk, pops - pops0);
    endtask

    initial begin
        int p;
        int to;
        reset       = 1'b1;
        start       = 1'b0;
        msg_words   = '0;
        last_bytes  = 4'd1;
        block_ready = 1'b1;
        fifo_empty  = 1'b1;
        fifo_data   = '0;
        repeat (3) @(negedge clk);
        check64("rst_busy", 64'(busy), 64'd0);
        check64("rst_valid", 64'(block_valid), 64'd0);
        check64("rst_last", 64'(block_last), 64'd0);
        check64("rst_done", 64'(done), 64'd0);
        check64("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check64("rst_data_zero", 64'(|block_data), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_msg(0, 5, 1'b0, 1'b0, 1'b0, 64'd0);
        run_msg(1, 3, 1'b0, 1'b0, 1'b1, 64'h1122334455667788);
        run_msg(17, 8, 1'b0, 1'b0, 1'b0, 64'd0);
        run_msg(34, 7, 1'b1, 1'b0, 1'b0, 64'd0);
        run_msg(20, 4, 1'b0, 1'b1, 1'b0, 64'd0);

        // Abandon a 10-word message after five captures.
        for (int i = 0; i < 10; i++) fifo_q.push_back({$urandom, $urandom});
        p = pops;
        @(negedge clk);
        start      = 1'b1;
        msg_words  = CNT_W'(10);
        last_bytes = 4'd8;
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while ((pops - p) < 5 && to < 1000) begin
            @(negedge clk);
            to++;
        end
        if ((pops - p) < 5) timeout_fail("reset_wait_pops");
        @(negedge clk);
        reset = 1'b1;
        p = pops;
        @(negedge clk);
        check64("mid_rst_busy", 64'(busy), 64'd0);
        check64("mid_rst_valid", 64'(block_valid), 64'd0);
        check64("mid_rst_last", 64'(block_last), 64'd0);
        check64("mid_rst_done", 64'(done), 64'd0);
        check64("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check64("mid_rst_data_zero", 64'(|block_data), 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check64("no_pops_after_reset", 64'(pops), 64'(p));
        $display("reset mid-message pops_before=%0d pops_after=%0d", p, pops);
        fifo_q.delete();
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            run_msg($urandom_range(0, 40), $urandom_range(1, 8), 1'b1, 1'b0, 1'b0, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
